// File: rtl/cmd_arg_decoder_pkg.sv
// cmd_dec_pkg: shared constants, state encoding and helpers for the command
// argument decoder (top cmd_arg_decoder, FIFO cmd_arg_fifo, bus interface).
package cmd_dec_pkg;

    localparam int          WORD_BITS     = 32;
    // Longest legal VLQ value in bytes; one more byte is an error.
    localparam logic [2:0]  VLQ_MAX_BYTES = 3'd5;
    // OR-ed into a first byte whose bits [6:5] are both set.
    localparam logic [31:0] SIGN_EXT      = 32'hFFFF_FFE0;

    typedef enum logic [2:0] {
        S_CMDID,
        S_ARGS,
        S_DISPATCH,
        S_EXEC,
        S_DISCARD
    } state_t;

    // States in which the message stream is being consumed.
    function automatic logic accepts_bytes(state_t s);
        return (s == S_CMDID) || (s == S_ARGS) || (s == S_DISCARD);
    endfunction

endpackage

// File: rtl/cmd_arg_decoder_if.sv
// cmd_arg_decoder_if: message byte stream plus the shared command/argument
// bus. The master modport is the decoder; the slave modport is its
// environment (message source and the executing unit).
interface cmd_arg_decoder_if
    import cmd_dec_pkg::*;
#(
    parameter int CMD_BITS = 6
) ();

    logic [7:0]           msg_data;
    logic                 msg_valid;
    logic                 msg_last;
    logic                 msg_ready;
    logic [CMD_BITS-1:0]  cmd;
    logic                 cmd_ready;
    logic [WORD_BITS-1:0] arg_data;
    logic                 arg_advance;
    logic                 cmd_done;
    logic                 decode_error;

    modport master (
        input  msg_data, msg_valid, msg_last, arg_advance, cmd_done,
        output msg_ready, cmd, cmd_ready, arg_data, decode_error
    );

    modport slave (
        output msg_data, msg_valid, msg_last, arg_advance, cmd_done,
        input  msg_ready, cmd, cmd_ready, arg_data, decode_error
    );

endinterface

// File: rtl/cmd_arg_decoder_fifo.sv
// cmd_arg_fifo: ARG_DEPTH x 32-bit argument FIFO with synchronous flush.
// The head output reads 0 whenever the FIFO is empty.
module cmd_arg_fifo
    import cmd_dec_pkg::*;
#(
    parameter int ARG_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] head,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(ARG_DEPTH);

    logic [WORD_BITS-1:0] mem [ARG_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; flush has priority over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale words are never
        // visible because head is forced to 0 while empty.
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cmd_arg_decoder.sv
// cmd_arg_decoder: decodes one framed message (VLQ command id followed by
// VLQ arguments) into an argument FIFO and dispatches it on the shared
// command bus. One command in flight; the next message waits for cmd_done.
// Optional macro CMD_DEC_ERRCNT_EN adds a saturating 16-bit err_count port.
module cmd_arg_decoder
    import cmd_dec_pkg::*;
#(
    parameter int CMD_BITS  = 6,
    parameter int ARG_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cmd_arg_decoder_if.master    bus
`ifdef CMD_DEC_ERRCNT_EN
    ,
    output logic [15:0]          err_count
`endif
);

    state_t               state;
    logic [WORD_BITS-1:0] acc;
    logic [2:0]           byte_cnt;
    logic [CMD_BITS-1:0]  cmd_q;
    logic                 msg_ready_q;
    logic                 cmd_ready_q;
    logic                 decode_error_q;

    logic                 accept;
    logic                 complete;
    logic                 err;
    logic [WORD_BITS-1:0] value;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [WORD_BITS-1:0] fifo_head;

    assign accept = bus.msg_valid && msg_ready_q;

    // VLQ step and error detection for the byte offered this cycle.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and every
        // output gets a default first so no latch can be inferred.
        value    = '0;
        complete = !bus.msg_data[7];
        err      = 1'b0;
        if (byte_cnt == 3'd0) begin
            value = {25'd0, bus.msg_data[6:0]};
            if (bus.msg_data[6:5] == 2'b11)
                value = value | SIGN_EXT;
        end else begin
            value = {acc[24:0], bus.msg_data[6:0]};
        end
        if (accept && (state == S_CMDID || state == S_ARGS)) begin
            if (byte_cnt == VLQ_MAX_BYTES)
                err = 1'b1;
            if (bus.msg_last && bus.msg_data[7])
                err = 1'b1;
            if (complete && state == S_CMDID && (value >> CMD_BITS) != '0)
                err = 1'b1;
            if (complete && state == S_ARGS && fifo_full)
                err = 1'b1;
        end
    end

    assign push  = accept && (state == S_ARGS) && complete && !err;
    assign pop   = bus.arg_advance && (state == S_DISPATCH || state == S_EXEC);
    assign flush = err || (state == S_EXEC && bus.cmd_done);

    cmd_arg_fifo #(
        .ARG_DEPTH (ARG_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (value),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Message/command state machine with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_CMDID;
            acc            <= '0;
            byte_cnt       <= '0;
            cmd_q          <= '0;
            msg_ready_q    <= 1'b0;
            cmd_ready_q    <= 1'b0;
            decode_error_q <= 1'b0;
        end else begin
            cmd_ready_q    <= 1'b0;
            decode_error_q <= 1'b0;
            case (state)
                S_CMDID, S_ARGS: begin
                    msg_ready_q <= 1'b1;
                    if (err) begin
                        decode_error_q <= 1'b1;
                        byte_cnt       <= '0;
                        state          <= bus.msg_last ? S_CMDID : S_DISCARD;
                    end else if (accept) begin
                        if (complete) begin
                            byte_cnt <= '0;
                            if (state == S_CMDID)
                                cmd_q <= value[CMD_BITS-1:0];
                            if (bus.msg_last) begin
                                state       <= S_DISPATCH;
                                msg_ready_q <= 1'b0;
                                cmd_ready_q <= 1'b1;
                            end else begin
                                state <= S_ARGS;
                            end
                        end else begin
                            acc      <= value;
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                S_DISPATCH: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (bus.cmd_done) begin
                        state       <= S_CMDID;
                        msg_ready_q <= accepts_bytes(S_CMDID);
                    end
                end
                S_DISCARD: begin
                    msg_ready_q <= 1'b1;
                    if (accept && bus.msg_last)
                        state <= S_CMDID;
                end
                default: begin
                    state       <= S_CMDID;
                    msg_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CMD_DEC_ERRCNT_EN
    // Saturating count of discarded messages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= '0;
        else if (err && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

    assign bus.msg_ready    = msg_ready_q;
    assign bus.cmd          = cmd_q;
    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.arg_data     = fifo_head;
    assign bus.decode_error = decode_error_q;

endmodule
